// File: rtl/clk_cfg_master.sv
// -----------------------------------------------------------------------------
// clk_cfg_master
// APB-to-clock-configuration bridge. Each APB access becomes exactly one
// req/ack transaction on the selected clock domain (soc, per, cluster), or a
// local status-register access (target 3).
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   psel_i/penable_i/pwrite_i    APB control
//   paddr_i[11:0]                [5:4] target, [3:2] register
//   pwdata_i / prdata_o          APB write / read data
//   pready_o / pslverr_o         APB response
//   <dom>_cfg_req_o/ack_i        per-domain request / acknowledge
//   <dom>_cfg_add_o/data_o/wrn_o latched address, write data, 1=write
//   <dom>_cfg_r_data_i           per-domain read data
//   <dom>_cfg_lock_i             PLL lock, asynchronous
//
// Optional feature: define CLK_CFG_TIMEOUT_EN to bound the ack wait to
// TIMEOUT_CYCLES cycles (error response 32'hdeadda7a plus sticky status bit 8).
// -----------------------------------------------------------------------------
module clk_cfg_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [11:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,

  output logic        soc_cfg_req_o,
  input  logic        soc_cfg_ack_i,
  output logic [1:0]  soc_cfg_add_o,
  output logic [31:0] soc_cfg_data_o,
  output logic        soc_cfg_wrn_o,
  input  logic [31:0] soc_cfg_r_data_i,
  input  logic        soc_cfg_lock_i,

  output logic        per_cfg_req_o,
  input  logic        per_cfg_ack_i,
  output logic [1:0]  per_cfg_add_o,
  output logic [31:0] per_cfg_data_o,
  output logic        per_cfg_wrn_o,
  input  logic [31:0] per_cfg_r_data_i,
  input  logic        per_cfg_lock_i,

  output logic        cluster_cfg_req_o,
  input  logic        cluster_cfg_ack_i,
  output logic [1:0]  cluster_cfg_add_o,
  output logic [31:0] cluster_cfg_data_o,
  output logic        cluster_cfg_wrn_o,
  input  logic [31:0] cluster_cfg_r_data_i,
  input  logic        cluster_cfg_lock_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } state_t;

  localparam logic [1:0]  TGT_LOCAL   = 2'd3;
  localparam logic [31:0] ERR_PATTERN = 32'hdeadda7a;

  state_t      r_state;
  logic [1:0]  r_tgt;
  logic [1:0]  r_add;
  logic [31:0] r_data;
  logic        r_wrn;
  logic [2:0]  r_req;
  logic        r_pready;
  logic [31:0] r_prdata;
  logic [2:0]  r_lock_meta;
  logic [2:0]  r_lock_sync;

  logic [2:0]  w_lock;
  logic        w_sel_ack;
  logic [31:0] w_sel_rdata;
  logic [2:0]  w_req_onehot;
  logic        w_sticky;
  logic [31:0] w_status;
  logic        w_access;
  logic [1:0]  w_tgt_in;
  logic [1:0]  w_reg_in;

  assign w_lock   = {cluster_cfg_lock_i, per_cfg_lock_i, soc_cfg_lock_i};
  assign w_access = psel_i & penable_i;
  assign w_tgt_in = paddr_i[5:4];
  assign w_reg_in = paddr_i[3:2];
  assign w_status = {23'd0, w_sticky, 5'd0, r_lock_sync};

`ifdef CLK_CFG_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sticky;
  logic             r_pslverr;

  assign w_sticky  = r_sticky;
  assign pslverr_o = r_pslverr;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign w_sticky     = 1'b0;
  assign pslverr_o    = 1'b0;
`endif

  logic w_unused_addr;
  assign w_unused_addr = ^{paddr_i[11:6], paddr_i[1:0]};

  // Ack and read data of the latched target only; acks from other domains
  // never influence the FSM.
  always_comb begin
    w_sel_ack   = 1'b0;
    w_sel_rdata = '0;
    case (r_tgt)
      2'd0: begin w_sel_ack = soc_cfg_ack_i;     w_sel_rdata = soc_cfg_r_data_i;     end
      2'd1: begin w_sel_ack = per_cfg_ack_i;     w_sel_rdata = per_cfg_r_data_i;     end
      2'd2: begin w_sel_ack = cluster_cfg_ack_i; w_sel_rdata = cluster_cfg_r_data_i; end
      default: ;
    endcase
  end

  always_comb begin
    w_req_onehot = '0;
    case (w_tgt_in)
      2'd0:    w_req_onehot = 3'b001;
      2'd1:    w_req_onehot = 3'b010;
      2'd2:    w_req_onehot = 3'b100;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock_meta <= '0;
      r_lock_sync <= '0;
    end else begin
      r_lock_meta <= w_lock;
      r_lock_sync <= r_lock_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_tgt     <= '0;
      r_add     <= '0;
      r_data    <= '0;
      r_wrn     <= 1'b0;
      r_req     <= '0;
      r_pready  <= 1'b0;
      r_prdata  <= '0;
`ifdef CLK_CFG_TIMEOUT_EN
      r_cnt     <= '0;
      r_sticky  <= 1'b0;
      r_pslverr <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            r_tgt  <= w_tgt_in;
            r_add  <= w_reg_in;
            r_wrn  <= pwrite_i;
            r_data <= pwdata_i;
            if (w_tgt_in == TGT_LOCAL) begin
              // Local register: answered straight from IDLE, no req issued.
              r_pready <= 1'b1;
              r_prdata <= (!pwrite_i && w_reg_in == 2'd0) ? w_status : '0;
`ifdef CLK_CFG_TIMEOUT_EN
              if (pwrite_i && w_reg_in == 2'd0 && pwdata_i[8])
                r_sticky <= 1'b0;
`endif
              r_state <= ST_DONE;
            end else begin
              r_req   <= w_req_onehot;
`ifdef CLK_CFG_TIMEOUT_EN
              r_cnt   <= '0;
`endif
              r_state <= ST_REQ;
            end
          end
        end

        ST_REQ: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (w_sel_ack) begin
            r_req    <= '0;
            r_pready <= 1'b1;
            r_prdata <= r_wrn ? '0 : w_sel_rdata;
            r_state  <= ST_DONE;
          end
`ifdef CLK_CFG_TIMEOUT_EN
          else if (r_cnt == CNT_LAST) begin
            r_req     <= '0;
            r_pready  <= 1'b1;
            r_pslverr <= 1'b1;
            r_prdata  <= ERR_PATTERN;
            r_sticky  <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end

        ST_DONE: begin
          r_pready  <= 1'b0;
          r_prdata  <= '0;
`ifdef CLK_CFG_TIMEOUT_EN
          r_pslverr <= 1'b0;
`endif
          r_state   <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifndef CLK_CFG_TIMEOUT_EN
  logic w_unused_err;
  assign w_unused_err = ^ERR_PATTERN;
`endif

  assign pready_o = r_pready;
  assign prdata_o = r_prdata;

  assign soc_cfg_req_o      = r_req[0];
  assign per_cfg_req_o      = r_req[1];
  assign cluster_cfg_req_o  = r_req[2];

  assign soc_cfg_add_o      = r_add;
  assign per_cfg_add_o      = r_add;
  assign cluster_cfg_add_o  = r_add;
  assign soc_cfg_data_o     = r_data;
  assign per_cfg_data_o     = r_data;
  assign cluster_cfg_data_o = r_data;
  assign soc_cfg_wrn_o      = r_wrn;
  assign per_cfg_wrn_o      = r_wrn;
  assign cluster_cfg_wrn_o  = r_wrn;

endmodule

// File: tb/tb_clk_cfg_master.sv
module tb_clk_cfg_master;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [2:0]  req, ack, lock;
  logic [1:0]  add [3];
  logic [31:0] data [3];
  logic [31:0] rdata [3];
  logic        wrn [3];

  always #5 clk = ~clk;

  clk_cfg_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
    .pready_o(pready), .pslverr_o(pslverr),
    .soc_cfg_req_o(req[0]), .soc_cfg_ack_i(ack[0]), .soc_cfg_add_o(add[0]),
    .soc_cfg_data_o(data[0]), .soc_cfg_wrn_o(wrn[0]),
    .soc_cfg_r_data_i(rdata[0]), .soc_cfg_lock_i(lock[0]),
    .per_cfg_req_o(req[1]), .per_cfg_ack_i(ack[1]), .per_cfg_add_o(add[1]),
    .per_cfg_data_o(data[1]), .per_cfg_wrn_o(wrn[1]),
    .per_cfg_r_data_i(rdata[1]), .per_cfg_lock_i(lock[1]),
    .cluster_cfg_req_o(req[2]), .cluster_cfg_ack_i(ack[2]), .cluster_cfg_add_o(add[2]),
    .cluster_cfg_data_o(data[2]), .cluster_cfg_wrn_o(wrn[2]),
    .cluster_cfg_r_data_i(rdata[2]), .cluster_cfg_lock_i(lock[2])
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Responder: target acks after 'delay' req cycles (delay 0 = ack tied 1),
  // other domains drive 'other_ack' constantly.
  int unsigned cnt [3] = '{0, 0, 0};
  int unsigned delay = 0;
  int          tgt = 0;
  bit          other_ack = 1'b0;

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) cnt[d] <= req[d] ? cnt[d] + 1 : 0;
  end

  always_comb begin
    ack = '0;
    for (int d = 0; d < 3; d++) begin
      if (d == tgt) ack[d] = (delay == 0) ? 1'b1 : (req[d] && cnt[d] >= delay);
      else          ack[d] = other_ack;
    end
  end

  // Monitor: req cycles per domain and stability of add/data/wrn while req.
  int unsigned req_cyc [3] = '{0, 0, 0};
  int unsigned stab_err = 0;
  logic [1:0]  exp_add;
  logic [31:0] exp_data;
  logic        exp_wrn;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (req[d] === 1'b1) begin
        req_cyc[d] <= req_cyc[d] + 1;
        if (add[d] !== exp_add || data[d] !== exp_data || wrn[d] !== exp_wrn)
          stab_err <= stab_err + 1;
      end
    end
  end

  task automatic apb(input logic [11:0] a, input logic w, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err, output int unsigned k);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (pready !== 1'b1 && k < 40);
    rd  = prdata;
    err = pslverr;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check("pready_one_cycle", {31'd0, pready}, 32'd0);
    check("prdata_idle_zero", prdata, 32'd0);
  endtask

  typedef struct {
    logic [11:0] paddr;
    logic        wr;
    logic [31:0] wdata;
    int unsigned delay;
    bit          oth;
    logic [2:0]  locks;
    logic [31:0] exp_rd;
    int unsigned exp_wait;
    logic        exp_err;
    int unsigned exp_reqc;
  } vec_t;

  vec_t vq [$];

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] rd;
    logic        err;
    int unsigned k, t;
    int unsigned c0 [3];
    int unsigned s0;
    lock = v.locks;
    t = int'(v.paddr[5:4]);
    tgt = t; delay = v.delay; other_ack = v.oth;
    exp_add = v.paddr[3:2]; exp_data = v.wdata; exp_wrn = v.wr;
    repeat (3) @(posedge clk);
    #1;
    c0 = req_cyc; s0 = stab_err;
    apb(v.paddr, v.wr, v.wdata, rd, err, k);
    check($sformatf("v%0d_prdata", idx), rd, v.exp_rd);
    check($sformatf("v%0d_pslverr", idx), {31'd0, err}, {31'd0, v.exp_err});
    check($sformatf("v%0d_wait", idx), k, v.exp_wait);
    for (int d = 0; d < 3; d++)
      check($sformatf("v%0d_reqcyc_d%0d", idx, d), req_cyc[d] - c0[d],
            (d == t) ? v.exp_reqc : 0);
    check($sformatf("v%0d_stable", idx), stab_err - s0, 32'd0);
  endtask

  initial begin
    int unsigned pr;
    rdata[0] = 32'hdeadda7a;
    rdata[1] = 32'hcafe_0001;
    rdata[2] = 32'h0bad_f00d;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; lock = '0;
    exp_add = '0; exp_data = '0; exp_wrn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", {29'd0, req}, 32'd0);
    check("rst_add", {26'd0, add[0], add[1], add[2]}, 32'd0);
    check("rst_data", data[0] | data[1] | data[2], 32'd0);
    check("rst_wrn", {29'd0, wrn[0], wrn[1], wrn[2]}, 32'd0);
    check("rst_pready", {31'd0, pready}, 32'd0);
    check("rst_pslverr", {31'd0, pslverr}, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    rst = 1'b0;

    vq.push_back('{12'h008, 1'b0, 32'h0000_0000, 0, 1'b0, 3'b000, 32'hdeadda7a, 2, 1'b0, 1});
    vq.push_back('{12'h024, 1'b1, 32'h1234_5678, 5, 1'b0, 3'b000, 32'h0000_0000, 7, 1'b0, 6});
    vq.push_back('{12'h01C, 1'b0, 32'h0000_0000, 2, 1'b1, 3'b000, 32'hcafe_0001, 4, 1'b0, 3});
    vq.push_back('{12'h020, 1'b0, 32'h0000_0000, 1, 1'b0, 3'b000, 32'h0bad_f00d, 3, 1'b0, 2});
    vq.push_back('{12'h004, 1'b1, 32'ha5a5_5a5a, 3, 1'b1, 3'b000, 32'h0000_0000, 5, 1'b0, 4});
    vq.push_back('{12'h030, 1'b0, 32'h0000_0000, 0, 1'b0, 3'b101, 32'h0000_0005, 1, 1'b0, 0});
    vq.push_back('{12'h030, 1'b0, 32'h0000_0000, 0, 1'b1, 3'b010, 32'h0000_0002, 1, 1'b0, 0});
    vq.push_back('{12'h034, 1'b0, 32'h0000_0000, 0, 1'b0, 3'b111, 32'h0000_0000, 1, 1'b0, 0});
    vq.push_back('{12'h038, 1'b1, 32'hffff_ffff, 0, 1'b0, 3'b111, 32'h0000_0000, 1, 1'b0, 0});
    vq.push_back('{12'h030, 1'b0, 32'h0000_0000, 0, 1'b0, 3'b111, 32'h0000_0007, 1, 1'b0, 0});
    vq.push_back('{12'h030, 1'b1, 32'h0000_0100, 0, 1'b0, 3'b000, 32'h0000_0000, 1, 1'b0, 0});
    vq.push_back('{12'h030, 1'b0, 32'h0000_0000, 0, 1'b0, 3'b000, 32'h0000_0000, 1, 1'b0, 0});
`ifdef CLK_CFG_TIMEOUT_EN
    vq.push_back('{12'h010, 1'b0, 32'h0000_0000, 1000, 1'b0, 3'b000, 32'hdeadda7a, 5, 1'b1, 4});
    vq.push_back('{12'h030, 1'b0, 32'h0000_0000, 0, 1'b0, 3'b011, 32'h0000_0103, 1, 1'b0, 0});
    vq.push_back('{12'h030, 1'b1, 32'h0000_0100, 0, 1'b0, 3'b011, 32'h0000_0000, 1, 1'b0, 0});
    vq.push_back('{12'h030, 1'b0, 32'h0000_0000, 0, 1'b0, 3'b011, 32'h0000_0003, 1, 1'b0, 0});
    vq.push_back('{12'h014, 1'b0, 32'h0000_0000, 3, 1'b0, 3'b000, 32'hcafe_0001, 5, 1'b0, 4});
    vq.push_back('{12'h030, 1'b0, 32'h0000_0000, 0, 1'b0, 3'b000, 32'h0000_0000, 1, 1'b0, 0});
`endif

    foreach (vq[i]) run_vec(vq[i], i);

    // Reset during the second REQ cycle of a per read that never acks.
    tgt = 1; delay = 1000; other_ack = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h010; pwdata = '0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    check("midrst_req_cycle1", {29'd0, req}, 32'd2);
    @(posedge clk); #1;
    check("midrst_req_cycle2", {29'd0, req}, 32'd2);
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check("midrst_req_dropped", {29'd0, req}, 32'd0);
    check("midrst_no_pready", {31'd0, pready}, 32'd0);
    rst = 1'b0;
    pr = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (pready === 1'b1 || req !== 3'b000) pr++;
    end
    check("midrst_quiet_after", pr, 32'd0);
    run_vec('{12'h008, 1'b0, 32'h0000_0000, 0, 1'b0, 3'b000, 32'hdeadda7a, 2, 1'b0, 1}, 99);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
